// File: rtl/mult_frame_accum.sv
// mult_frame_accum: sums FRAME_LEN consecutive accepted 16-bit products into
// one frame total and presents it on a registered valid/ready output port.
//
// Optional feature macro: ACC_SAT_EN (defined: the running sum saturates at
// 2^ACC_W-1 on carry out; undefined: the sum wraps modulo 2^ACC_W). In both
// builds ovf reports that the frame total exceeded ACC_W bits.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   in_valid   in   product valid this cycle
//   in_ready   out  product can be accepted this cycle (combinational)
//   product    in   16-bit multiplier output sample
//   clr        in   synchronous clear of the partial frame
//   out_valid  out  frame total available (registered)
//   out_ready  in   downstream accepts the frame total
//   acc_out    out  frame total (registered)
//   ovf        out  frame total overflowed ACC_W (registered with acc_out)
module mult_frame_accum #(
   parameter int unsigned FRAME_LEN = 16,
   parameter int unsigned ACC_W     = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      product,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
   localparam int unsigned SUM_W = ACC_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_run_q, ovf_run_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   acc_out_q, acc_out_d;
   logic               ovf_q, ovf_d;

   logic               accept;
   logic               drain;
   logic [SUM_W-1:0]   sum;
   logic               carry;
   logic [ACC_W-1:0]   add_res;

   // Input handshake: HOLD only takes a new sample when the total drains
   // in the same cycle, so a new frame can start with no bubble.
   always_comb begin
      in_ready = 1'b0;
      if (rst && !clr) begin
         if (state_q == HOLD) begin
            in_ready = out_ready;
         end else begin
            in_ready = 1'b1;
         end
      end
   end

   assign accept = in_valid & in_ready;
   assign drain  = out_valid_q & out_ready;

   // One extra bit catches the carry out of the accumulator width.
   assign sum   = SUM_W'(acc_q) + SUM_W'(product);
   assign carry = sum[ACC_W];

`ifdef ACC_SAT_EN
   // Clamp on carry; once at the max value every later add carries or adds
   // zero, so the clamp holds for the rest of the frame.
   assign add_res = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign add_res = sum[ACC_W-1:0];
`endif

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_run_d   = ovf_run_q;
      out_valid_d = out_valid_q;
      acc_out_d   = acc_out_q;
      ovf_d       = ovf_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               acc_d     = ACC_W'(product);
               cnt_d     = CNT_W'(1);
               ovf_run_d = 1'b0;
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                  acc_out_d   = add_res;
                  ovf_d       = ovf_run_q | carry;
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  cnt_d       = '0;
                  ovf_run_d   = 1'b0;
                  state_d     = HOLD;
               end else begin
                  acc_d     = add_res;
                  cnt_d     = cnt_q + CNT_W'(1);
                  ovf_run_d = ovf_run_q | carry;
               end
            end
         end
         HOLD: begin
            if (drain) begin
               out_valid_d = 1'b0;
               if (accept) begin
                  acc_d     = ACC_W'(product);
                  cnt_d     = CNT_W'(1);
                  ovf_run_d = 1'b0;
                  state_d   = ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Clear drops the partial frame only; a pending total still drains.
      if (clr) begin
         acc_d     = '0;
         cnt_d     = '0;
         ovf_run_d = 1'b0;
         if (state_q != HOLD) begin
            state_d = IDLE;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_run_q   <= 1'b0;
         out_valid_q <= 1'b0;
         acc_out_q   <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_run_q   <= ovf_run_d;
         out_valid_q <= out_valid_d;
         acc_out_q   <= acc_out_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign acc_out   = acc_out_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/mult_frame_accum.md
Name: mult_frame_accum

Overview:
- Downstream consumer of the 8x8 approximate multiplier's 16-bit product stream.
- Sums FRAME_LEN consecutive accepted products into one frame total. Typical use: dot products and filter taps.
- Presents each frame total on a registered valid/ready output port with full backpressure.
- A synchronous clear abandons a partial frame.

Parameters:
- FRAME_LEN, 16, number of products per frame; legal range 2..256.
- ACC_W, 20, accumulator and output width. Default 20 holds 16 x 255 x 255 = 1,040,400 without overflow.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  product is valid this cycle.
- in_ready  out  1  block can accept product this cycle.
- product  in  16  multiplier output sample.
- clr  in  1  synchronous clear of the partial frame.
- out_valid  out  1  frame total available.
- out_ready  in  1  downstream accepts the frame total.
- acc_out  out  ACC_W  frame total, registered.
- ovf  out  1  frame total overflowed ACC_W, registered with acc_out.

Behaviour:
- Reset and clock: one clock, clk. Reset is synchronous, active-low (rst=0 sampled on the clk edge).
- Reset values: state=IDLE, acc=0, cnt=0, out_valid=0, acc_out=0, ovf=0. in_ready=0 while rst=0.
- Accept: in_valid & in_ready on a rising edge.
- In states IDLE and ACCUM, in_ready=1 unless clr=1.
- States:
  - IDLE: on accept, acc<=product, cnt<=1, ovf_run<=0, go to ACCUM.
  - ACCUM: on accept, acc<=acc+product, cnt<=cnt+1, ovf_run sets on carry out of ACC_W.
    - If the accept has cnt==FRAME_LEN-1: acc_out<=final sum, ovf<=final ovf_run, out_valid<=1, acc<=0, cnt<=0, go to HOLD.
  - HOLD: in_ready=out_ready & ~clr (combinational).
    - out_valid and acc_out/ovf hold stable until out_valid & out_ready.
    - Drain without accept: out_valid<=0, go to IDLE.
    - Drain with accept in the same cycle: out_valid<=0, acc<=product, cnt<=1, go to ACCUM. No bubble.
- Latency: out_valid is high in the cycle after the edge that accepts the last sample of a frame.
- Throughput: one product per clock with out_ready held at 1.
- Arithmetic: product is zero-extended to ACC_W. Without ACC_SAT_EN the sum wraps modulo 2^ACC_W. ovf is sticky across the frame.
- clr:
  - Clears acc, cnt and ovf_run; state goes to IDLE, or stays HOLD.
  - A pending HOLD output is retained and still drains normally.
  - clr has priority over an in_valid in the same cycle; in_ready=0, so the sample is not accepted.
- rst mid-frame or mid-HOLD: all state returns to reset values on that edge; the pending output is lost.
- in_valid while in_ready=0: no effect; upstream must hold product.
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: the add saturates.
  - On carry out, acc clamps to 2^ACC_W-1 and stays there for the rest of the frame.
  - ovf=1 for that frame.
- Undefined: modulo wrap as above; ovf still reports the carry.

Test Plan:
1. Hold rst=0 for 3 cycles with in_valid=1, product=0x1234 -> out_valid=0, acc_out=0, ovf=0, in_ready=0. After rst=1, in_ready=1 and nothing is accepted during reset.
2. Defaults, out_ready=1, 16 back-to-back accepts of product=0x0100 -> out_valid high exactly 1 cycle after the 16th accept, acc_out=4096, ovf=0.
3. Complete a frame with out_ready=0 for 5 cycles -> in_ready=0 and acc_out stable all 5 cycles. Then out_ready=1 with in_valid=1, product=5 -> drain and accept in the same cycle. Next frame of 5 plus 15 x 1 gives acc_out=20.
4. After 7 accepted samples of 0x0010, clr=1 with in_valid=1 -> sample not accepted. Then 16 samples of 1 -> acc_out=16.
5. ACC_W=16, 16 samples of 0xFFFF:
   - Macro undefined -> acc_out=0xFFF0, ovf=1.
   - With ACC_SAT_EN -> acc_out=0xFFFF, ovf=1.
   - Next frame of 16 x 1 -> acc_out=16, ovf=0.
6. rst=0 asserted while in HOLD with out_valid=1 -> out_valid=0, acc_out=0 after that edge. A fresh 16-sample frame of 2 afterwards gives acc_out=32.
